axi4lite_master_seq: RTL and testbench

// - AXI4-lite initiator that issues single 32-bit register writes and reads over one ctrl AXI4-lite port.
// - Drives the control register block's slave port from on-chip or bench logic, e.g. board load and move readback, with no PS in the loop.
// - Simple valid/ready command in, one-cycle response pulse out; at most one transaction outstanding.

---
 rtl/axi4lite_master_seq.sv | 218 +++++++++++++++++++++
 tb/tb_axi4lite_master_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master_seq.sv
`default_nettype none
// ============================================================================
// axi4lite_master_seq : single-outstanding AXI4-lite initiator (one write or
// read per command, one-cycle response pulse).         Revision 1.0
// ============================================================================
module axi4lite_master_seq #(
   parameter int ADDR_WIDTH     = 40,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  aresetb,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] axi_awaddr,
   output logic [2:0]            axi_awprot,
   output logic                  axi_awvalid,
   input  logic                  axi_awready,
   output logic [31:0]           axi_wdata,
   output logic [3:0]            axi_wstrb,
   output logic                  axi_wvalid,
   input  logic                  axi_wready,
   input  logic [1:0]            axi_bresp,
   input  logic                  axi_bvalid,
   output logic                  axi_bready,
   output logic [ADDR_WIDTH-1:0] axi_araddr,
   output logic [2:0]            axi_arprot,
   output logic                  axi_arvalid,
   input  logic                  axi_arready,
   input  logic [31:0]           axi_rdata,
   input  logic [1:0]            axi_rresp,
   input  logic                  axi_rvalid,
   output logic                  axi_rready
);

   localparam int                CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0]     TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [1:0]        RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR_AD = 3'd1,
      ST_WR_B  = 3'd2,
      ST_RD_A  = 3'd3,
      ST_RD_R  = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              wstrb_q, wstrb_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [31:0]             rsp_rdata_q, rsp_rdata_d;
   logic [1:0]              rsp_resp_q, rsp_resp_d;
   logic                    rsp_timeout_q, rsp_timeout_d;
   logic [CW-1:0]           tcnt_q, tcnt_d;
   logic                    aw_done, w_done, timeout_hit;

   assign aw_done     = !awvalid_q || axi_awready;
   assign w_done      = !wvalid_q  || axi_wready;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TO_LAST);

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      tcnt_d        = tcnt_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WR_AD;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_A;
               end
            end
         end
         ST_WR_AD: begin
            // AW and W complete independently; leave once both are done.
            if (awvalid_q && axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
            if (aw_done && w_done) begin
               bready_d = 1'b1;
               tcnt_d   = '0;
               state_d  = ST_WR_B;
            end
         end
         ST_WR_B: begin
            if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
            if (axi_bvalid) begin
               bready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_resp_d    = axi_bresp;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b0;
               state_d       = ST_IDLE;
            end else if (timeout_hit) begin
               bready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_resp_d    = RESP_SLVERR;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_RD_A: begin
            if (axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               tcnt_d    = '0;
               state_d   = ST_RD_R;
            end
         end
         ST_RD_R: begin
            if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
            // A handshake in the timeout cycle takes precedence.
            if (axi_rvalid) begin
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_resp_d    = axi_rresp;
               rsp_rdata_d   = axi_rdata;
               rsp_timeout_d = 1'b0;
               state_d       = ST_IDLE;
            end else if (timeout_hit) begin
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_resp_d    = RESP_SLVERR;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetb) begin
      if (!aresetb) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= '0;
         rsp_timeout_q <= 1'b0;
         tcnt_q        <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
         tcnt_q        <= tcnt_d;
      end
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_resp    = rsp_resp_q;
   assign rsp_timeout = rsp_timeout_q;
   assign axi_awaddr  = addr_q;
   assign axi_awprot  = 3'b000;
   assign axi_awvalid = awvalid_q;
   assign axi_wdata   = wdata_q;
   assign axi_wstrb   = wstrb_q;
   assign axi_wvalid  = wvalid_q;
   assign axi_bready  = bready_q;
   assign axi_araddr  = addr_q;
   assign axi_arprot  = 3'b000;
   assign axi_arvalid = arvalid_q;
   assign axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_master_seq.sv
`default_nettype none
// ============================================================================
// tb_axi4lite_master_seq : directed vector bench with a delay-programmable
// AXI4-lite slave model.                                Revision 1.0
// ============================================================================
module tb_axi4lite_master_seq;
   localparam int AW = 40;
   localparam int TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic aresetb, cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0] cmd_wstrb;
   logic rsp_valid, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0] rsp_resp;
   logic [AW-1:0] axi_awaddr, axi_araddr;
   logic [2:0] axi_awprot, axi_arprot;
   logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
   logic axi_arvalid, axi_arready, axi_rvalid, axi_rready;
   logic [31:0] axi_wdata, axi_rdata;
   logic [3:0] axi_wstrb;
   logic [1:0] axi_bresp, axi_rresp;

   axi4lite_master_seq #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .aresetb(aresetb),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
   );

   // Slave model: each ready/valid asserts once its wait count reaches the programmed delay.
   int aw_dly, w_dly, b_dly, ar_dly, r_dly;
   bit never;
   logic [1:0] s_bresp, s_rresp;
   logic [31:0] s_rdata;
   int aw_wait, w_wait, b_wait, ar_wait, r_wait;

   initial begin
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_arready = 0; axi_rvalid = 0;
      axi_bresp = 0; axi_rresp = 0; axi_rdata = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
   end

   always @(negedge clk) begin
      if (axi_awvalid) begin axi_awready = (aw_wait >= aw_dly); aw_wait++; end
      else begin axi_awready = 0; aw_wait = 0; end
      if (axi_wvalid) begin axi_wready = (w_wait >= w_dly); w_wait++; end
      else begin axi_wready = 0; w_wait = 0; end
      if (axi_arvalid) begin axi_arready = (ar_wait >= ar_dly); ar_wait++; end
      else begin axi_arready = 0; ar_wait = 0; end
      if (axi_bready && !never) begin axi_bvalid = (b_wait >= b_dly); b_wait++; end
      else begin axi_bvalid = 0; b_wait = 0; end
      if (axi_rready && !never) begin axi_rvalid = (r_wait >= r_dly); r_wait++; end
      else begin axi_rvalid = 0; r_wait = 0; end
      axi_bresp = s_bresp;
      axi_rresp = s_rresp;
      axi_rdata = axi_rvalid ? s_rdata : 32'h0;
   end

   // Bus monitor
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, aw_hi = 0, w_hi = 0, rsp_cnt = 0;
   logic [AW-1:0] cap_awaddr, cap_araddr;
   logic [31:0] cap_wdata;
   logic [3:0] cap_wstrb;
   logic [31:0] rsp_log[$];

   always @(posedge clk) begin
      if (axi_awvalid) aw_hi <= aw_hi + 1;
      if (axi_wvalid)  w_hi  <= w_hi + 1;
      if (axi_awvalid && axi_awready) begin aw_hs <= aw_hs + 1; cap_awaddr <= axi_awaddr; end
      if (axi_wvalid && axi_wready) begin w_hs <= w_hs + 1; cap_wdata <= axi_wdata; cap_wstrb <= axi_wstrb; end
      if (axi_bvalid && axi_bready) b_hs <= b_hs + 1;
      if (axi_arvalid && axi_arready) begin ar_hs <= ar_hs + 1; cap_araddr <= axi_araddr; end
      if (axi_rvalid && axi_rready) r_hs <= r_hs + 1;
      if (rsp_valid) begin rsp_cnt <= rsp_cnt + 1; rsp_log.push_back(rsp_rdata); end
   end

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      bit wr; logic [AW-1:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
      int aw_d, w_d, b_d, ar_d, r_d; bit nev;
      logic [1:0] sresp; logic [31:0] srdata;
      logic [31:0] exp_rdata; logic [1:0] exp_resp; bit exp_to;
      int exp_lat, exp_awhi, exp_whi;
   } vec_t;

   vec_t vecs[10];

   // Latency = number of negedges after the accepting posedge until rsp_valid is seen.
   task automatic apply_vec(input vec_t v, input string tag);
      int aw0, w0, b0, ar0, r0, awh0, wh0, rc0, lat;
      bit got, acc;
      aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
      never = v.nev; s_bresp = v.sresp; s_rresp = v.sresp; s_rdata = v.srdata;
      @(negedge clk);
      aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
      awh0 = aw_hi; wh0 = w_hi; rc0 = rsp_cnt;
      cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
      acc = 0;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(posedge clk);
         acc = cmd_ready;
      end
      chk({tag, ".accepted"}, acc, 1);
      @(negedge clk);
      cmd_valid = 0;
      got = 0; lat = 0;
      for (int i = 1; i <= 60 && !got; i++) begin
         if (i > 1) @(negedge clk);
         if (rsp_valid) begin got = 1; lat = i; end
      end
      chk({tag, ".rsp_seen"}, got, 1);
      chk({tag, ".latency"}, lat, v.exp_lat);
      chk({tag, ".rdata"}, rsp_rdata, v.exp_rdata);
      chk({tag, ".resp"}, rsp_resp, v.exp_resp);
      chk({tag, ".timeout"}, rsp_timeout, v.exp_to);
      chk({tag, ".cmd_ready_at_rsp"}, cmd_ready, 1);
      @(negedge clk);
      chk({tag, ".rsp_one_cycle"}, rsp_valid, 0);
      chk({tag, ".rsp_count"}, rsp_cnt - rc0, 1);
      chk({tag, ".rdata_hold"}, rsp_rdata, v.exp_rdata);
      chk({tag, ".bready_low"}, axi_bready, 0);
      chk({tag, ".rready_low"}, axi_rready, 0);
      chk({tag, ".aw_hs"}, aw_hs - aw0, v.wr ? 1 : 0);
      chk({tag, ".w_hs"}, w_hs - w0, v.wr ? 1 : 0);
      chk({tag, ".b_hs"}, b_hs - b0, (v.wr && !v.nev) ? 1 : 0);
      chk({tag, ".ar_hs"}, ar_hs - ar0, v.wr ? 0 : 1);
      chk({tag, ".r_hs"}, r_hs - r0, (!v.wr && !v.nev) ? 1 : 0);
      chk({tag, ".awvalid_cycles"}, aw_hi - awh0, v.exp_awhi);
      chk({tag, ".wvalid_cycles"}, w_hi - wh0, v.exp_whi);
      if (v.wr) begin
         chk({tag, ".awaddr"}, cap_awaddr, v.addr);
         chk({tag, ".wdata"}, cap_wdata, v.wdata);
         chk({tag, ".wstrb"}, cap_wstrb, v.wstrb);
      end else begin
         chk({tag, ".araddr"}, cap_araddr, v.addr);
      end
   endtask

   vec_t rv;
   int rc_base, acc_n, aw0, w0, b0, ar0, r0;
   bit hit, in_rr;

   initial begin
      //           wr addr              wdata         strb  aw w  b  ar r  nev sresp srdata         exp_rdata      resp  to lat awhi whi
      vecs[0] = '{1, 40'h4,            32'h5,        4'hF, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0,         32'h0,         2'd0, 0, 3,  1,   1};
      vecs[1] = '{1, 40'h10,           32'hA5A50001, 4'h3, 3, 0, 0, 0, 0, 0, 2'd0, 32'h0,         32'h0,         2'd0, 0, 6,  4,   1};
      vecs[2] = '{0, 40'h21C,          32'h0,        4'hF, 0, 0, 0, 0, 0, 0, 2'd0, 32'hDEADBEEF,  32'hDEADBEEF,  2'd0, 0, 3,  0,   0};
      vecs[3] = '{0, 40'h1_0000_0040,  32'h0,        4'h0, 0, 0, 0, 0, 1, 0, 2'd1, 32'h12345678,  32'h12345678,  2'd1, 0, 4,  0,   0};
      vecs[4] = '{1, 40'hFF_FFFF_FFFC, 32'h0000FFFF, 4'h8, 0, 2, 2, 0, 0, 0, 2'd3, 32'h0,         32'h0,         2'd3, 0, 7,  1,   3};
      vecs[5] = '{0, 40'h8,            32'h0,        4'h0, 0, 0, 0, 2, 0, 0, 2'd0, 32'hCAFEF00D,  32'hCAFEF00D,  2'd0, 0, 5,  0,   0};
      vecs[6] = '{1, 40'h30,           32'h1,        4'hF, 0, 0, 0, 0, 0, 1, 2'd0, 32'h0,         32'h0,         2'd2, 1, 18, 1,   1};
      vecs[7] = '{1, 40'h34,           32'h2,        4'hF, 0, 0, 15, 0, 0, 0, 2'd0, 32'h0,        32'h0,         2'd0, 0, 18, 1,   1};
      vecs[8] = '{0, 40'h38,           32'h0,        4'h0, 0, 0, 0, 0, 0, 1, 2'd0, 32'h77,        32'h0,         2'd2, 1, 18, 0,   0};
      vecs[9] = '{0, 40'h3C,           32'h0,        4'h0, 0, 0, 0, 0, 2, 0, 2'd2, 32'h600DCAFE,  32'h600DCAFE,  2'd2, 0, 5,  0,   0};

      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; never = 0;
      s_bresp = 0; s_rresp = 0; s_rdata = 0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      aresetb = 0;
      repeat (3) @(negedge clk);
      chk("reset.awvalid", axi_awvalid, 0);
      chk("reset.wvalid", axi_wvalid, 0);
      chk("reset.arvalid", axi_arvalid, 0);
      chk("reset.bready", axi_bready, 0);
      chk("reset.rready", axi_rready, 0);
      chk("reset.rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 0);
      chk("reset.addr", axi_awaddr, 0);
      chk("reset.prot", {axi_awprot, axi_arprot}, 0);
      aresetb = 1;
      @(negedge clk);
      chk("reset.cmd_ready", cmd_ready, 1);

      for (int k = 0; k < 10; k++) apply_vec(vecs[k], $sformatf("vec%0d", k));

      // Reset while waiting in RD_R: everything drops at once, no response.
      never = 1; ar_dly = 0;
      @(negedge clk);
      rc_base = rsp_cnt;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 40'h80;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 0;
      in_rr = 0;
      for (int i = 0; i < 10 && !in_rr; i++) begin
         @(negedge clk);
         in_rr = axi_rready;
      end
      chk("rst_mid.reached_rd_r", in_rr, 1);
      aresetb = 0;
      #1;
      chk("rst_mid.valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, rsp_valid}, 0);
      chk("rst_mid.araddr", axi_araddr, 0);
      @(negedge clk);
      aresetb = 1;
      never = 0;
      repeat (20) @(negedge clk);
      chk("rst_mid.no_rsp", rsp_cnt - rc_base, 0);
      chk("rst_mid.cmd_ready", cmd_ready, 1);
      rv = vecs[2];
      rv.addr = 40'h84; rv.srdata = 32'h13579BDF; rv.exp_rdata = 32'h13579BDF;
      apply_vec(rv, "rst_mid.next_read");

      // cmd_valid held across W, R, W.
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; never = 0;
      s_bresp = 0; s_rresp = 0; s_rdata = 32'h0BADF00D;
      @(negedge clk);
      aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs; rc_base = rsp_cnt;
      rsp_log.delete();
      acc_n = 0;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 40'h100; cmd_wdata = 32'h11; cmd_wstrb = 4'hF;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(posedge clk);
         hit = cmd_ready && cmd_valid;
         @(negedge clk);
         if (hit) begin
            acc_n++;
            if (acc_n == 1) begin cmd_write = 0; cmd_addr = 40'h104; end
            else if (acc_n == 2) begin cmd_write = 1; cmd_addr = 40'h108; cmd_wdata = 32'h22; end
            else cmd_valid = 0;
         end
         if (rsp_valid) chk("b2b.cmd_ready_with_rsp", cmd_ready, 1);
      end
      chk("b2b.accepted", acc_n, 3);
      chk("b2b.rsp_count", rsp_cnt - rc_base, 3);
      chk("b2b.aw_hs", aw_hs - aw0, 2);
      chk("b2b.w_hs", w_hs - w0, 2);
      chk("b2b.b_hs", b_hs - b0, 2);
      chk("b2b.ar_hs", ar_hs - ar0, 1);
      chk("b2b.r_hs", r_hs - r0, 1);
      chk("b2b.last_awaddr", cap_awaddr, 40'h108);
      chk("b2b.last_wdata", cap_wdata, 32'h22);
      chk("b2b.araddr", cap_araddr, 40'h104);
      chk("b2b.log_size", rsp_log.size(), 3);
      if (rsp_log.size() == 3) begin
         chk("b2b.rsp0_write", rsp_log[0], 32'h0);
         chk("b2b.rsp1_read", rsp_log[1], 32'h0BADF00D);
         chk("b2b.rsp2_write", rsp_log[2], 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
